// File: rtl/counter_32bit_pkg.sv
// Shared constants for the 32-bit sliced cycle/event counter.
package counter_32bit_pkg;

    localparam int WIDTH   = 32;
    localparam int SLICE_W = 8;
    localparam int SLICES  = WIDTH / SLICE_W;

endpackage

// File: rtl/counter_32bit_slice8.sv
// One 8-bit counter slice: registered value plus combinational carry-out.
module counter_slice8
    import counter_32bit_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [SLICE_W-1:0] en_add,
    input  logic               cin,
    output logic [SLICE_W-1:0] q,
    output logic               cout
);

    logic [SLICE_W-1:0] q_q;
    logic [SLICE_W-1:0] q_d;
    logic [SLICE_W:0]   sum;

    always_comb begin
        sum = {1'b0, q_q}
            + {1'b0, en_add}
            + {{SLICE_W{1'b0}}, cin};
        q_d = reset ? '0 : sum[SLICE_W-1:0];
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q    = q_q;
    assign cout = sum[SLICE_W];

endmodule

// File: rtl/counter_32bit.sv
// Free-running 32-bit counter built from four rippled 8-bit slices;
// each edge adds 1, or para when addStart is high.
module counter_32bit
    import counter_32bit_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count,
    input  logic             addStart,
    input  logic [7:0]       para
);

    logic [SLICE_W-1:0] op0;
    logic [SLICES:0]    carry;
    logic               wrap_unused;

    always_comb begin
        op0 = addStart ? para : 8'd1;
    end

    assign carry[0]    = 1'b0;
    assign wrap_unused = carry[SLICES];

    for (genvar k = 0; k < SLICES; k++) begin : gen_slice
        logic [SLICE_W-1:0] operand;
        logic [SLICE_W-1:0] q;

        // Only the low slice sees the operand; the rest take the carry.
        assign operand = (k == 0) ? op0 : '0;

        counter_slice8 u_slice (
            .clk    (clk),
            .reset  (reset),
            .en_add (operand),
            .cin    (carry[k]),
            .q      (q),
            .cout   (carry[k+1])
        );

        assign count[k*SLICE_W +: SLICE_W] = q;
    end

endmodule

// File: tb/tb_counter_32bit.sv
// Directed self-checking bench for counter_32bit.
module tb_counter_32bit;

    logic        clk;
    logic        reset;
    logic [31:0] count;
    logic        addStart;
    logic [7:0]  para;

    int errors;
    int checks;
    logic [31:0] preload_val;

    counter_32bit dut (
        .clk      (clk),
        .reset    (reset),
        .count    (count),
        .addStart (addStart),
        .para     (para)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after a falling edge; one call spans one rising edge.
    task automatic step(input logic r, input logic a, input logic [7:0] p);
        reset    = r;
        addStart = a;
        para     = p;
        @(negedge clk);
    endtask

    // Seed the slice registers directly so high values are reachable quickly.
    task automatic preload(input logic [31:0] v);
        preload_val = v;
        force dut.gen_slice[0].u_slice.q_q = preload_val[7:0];
        force dut.gen_slice[1].u_slice.q_q = preload_val[15:8];
        force dut.gen_slice[2].u_slice.q_q = preload_val[23:16];
        force dut.gen_slice[3].u_slice.q_q = preload_val[31:24];
        #1;
        release dut.gen_slice[0].u_slice.q_q;
        release dut.gen_slice[1].u_slice.q_q;
        release dut.gen_slice[2].u_slice.q_q;
        release dut.gen_slice[3].u_slice.q_q;
        #1;
    endtask

    task automatic test_reset;
        preload(32'h1234_5678);
        checks++;
        if (count !== 32'h1234_5678) begin
            errors++;
            $display("FAIL preload got=%h exp=%h", count, 32'h1234_5678);
        end
        step(1'b1, 1'b0, 8'h00);
        checks++;
        if (count !== 32'h0) begin
            errors++;
            $display("FAIL reset got=%h exp=%h", count, 32'h0);
        end
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b0, 8'h00);
            checks++;
            if (count !== 32'(i)) begin
                errors++;
                $display("FAIL count_up%0d got=%h exp=%h", i, count, 32'(i));
            end
        end
    endtask

    task automatic test_offset_add;
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 8'h00);
        checks++;
        if (count !== 32'h7) begin
            errors++;
            $display("FAIL at_seven got=%h exp=%h", count, 32'h7);
        end
        step(1'b0, 1'b1, 8'h28);
        checks++;
        if (count !== 32'h2F) begin
            errors++;
            $display("FAIL offset_add got=%h exp=%h", count, 32'h2F);
        end
        step(1'b0, 1'b0, 8'h28);
        checks++;
        if (count !== 32'h30) begin
            errors++;
            $display("FAIL after_add got=%h exp=%h", count, 32'h30);
        end
    endtask

    task automatic test_level_add;
        logic [31:0] exp_v [3];
        exp_v[0] = 32'h28;
        exp_v[1] = 32'h50;
        exp_v[2] = 32'h78;
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'h28);
            checks++;
            if (count !== exp_v[i]) begin
                errors++;
                $display("FAIL level_add%0d got=%h exp=%h", i, count, exp_v[i]);
            end
        end
    endtask

    task automatic test_slice_carry;
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'hFF);
        checks++;
        if (count !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL load_ff got=%h exp=%h", count, 32'hFF);
        end
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if (count !== 32'h0000_0100) begin
            errors++;
            $display("FAIL carry_s1 got=%h exp=%h", count, 32'h100);
        end
        preload(32'h00FF_FFFF);
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if (count !== 32'h0100_0000) begin
            errors++;
            $display("FAIL carry_s3 got=%h exp=%h", count, 32'h0100_0000);
        end
        preload(32'h0000_FFF0);
        step(1'b0, 1'b1, 8'h80);
        checks++;
        if (count !== 32'h0001_0070) begin
            errors++;
            $display("FAIL carry_add got=%h exp=%h", count, 32'h0001_0070);
        end
    endtask

    task automatic test_wrap;
        preload(32'hFFFF_FFFE);
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if (count !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_max got=%h exp=%h", count, 32'hFFFF_FFFF);
        end
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if (count !== 32'h0) begin
            errors++;
            $display("FAIL wrap_zero got=%h exp=%h", count, 32'h0);
        end
        preload(32'hFFFF_FFF0);
        step(1'b0, 1'b1, 8'h20);
        checks++;
        if (count !== 32'h0000_0010) begin
            errors++;
            $display("FAIL wrap_add got=%h exp=%h", count, 32'h10);
        end
    endtask

    task automatic test_priority;
        preload(32'h0000_1234);
        step(1'b1, 1'b1, 8'h28);
        checks++;
        if (count !== 32'h0) begin
            errors++;
            $display("FAIL reset_over_add got=%h exp=%h", count, 32'h0);
        end
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if (count !== 32'h2) begin
            errors++;
            $display("FAIL resume got=%h exp=%h", count, 32'h2);
        end
        step(1'b0, 1'b1, 8'h00);
        checks++;
        if (count !== 32'h2) begin
            errors++;
            $display("FAIL zero_add got=%h exp=%h", count, 32'h2);
        end
        step(1'b0, 1'b0, 8'h00);
        checks++;
        if (count !== 32'h3) begin
            errors++;
            $display("FAIL after_zero got=%h exp=%h", count, 32'h3);
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        reset    = 1'b1;
        addStart = 1'b0;
        para     = 8'h00;
        @(negedge clk);
        test_reset();
        test_offset_add();
        test_level_add();
        test_slice_carry();
        test_wrap();
        test_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
